// File: rtl/rt_uart_rx.sv
// rt_uart_rx: 8N1 UART receiver with a small receive FIFO.
// Sticky frame-error and overrun flags, cleared by clear_i.
`timescale 1ns/1ps
module rt_uart_rx #(
    parameter int ClkFreqHz = 30_000_000,
    parameter int BaudRate  = 3_000_000,
    parameter int FifoDepth = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rx_i,
    output logic [7:0]                     data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [$clog2(FifoDepth+1)-1:0] count_o,
    output logic                           busy_o,
    output logic                           frame_err_o,
    output logic                           overrun_o,
    input  logic                           clear_i
);

    localparam int CPB   = ClkFreqHz / BaudRate;
    localparam int CntW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccW  = $clog2(FifoDepth + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(CPB - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CPB / 2 - 1);
    localparam logic [OccW-1:0] OccFull = OccW'(FifoDepth);

    generate
        if (CPB < 4) begin : g_bad_cpb
            $fatal(1, "rt_uart_rx: clocks per bit must be at least 4");
        end
        if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
            $fatal(1, "rt_uart_rx: FifoDepth must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            push;
    logic [7:0]      push_data;

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            pop;
    logic            full;
    logic            wr_ok;
    logic            drop;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: centre-samples each bit and hands good bytes to the FIFO a cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            push        <= 1'b0;
            push_data   <= '0;
            busy_o      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            push   <= 1'b0;
            busy_o <= (state != IDLE);
            if (clear_i) begin
                frame_err_o <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CntHalf) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CntLast) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CntLast) begin
                        cnt <= '0;
                        if (rx_s) begin
                            push      <= 1'b1;
                            push_data <= shreg;
                            state     <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid_o = (count_o != '0);
    assign data_o  = mem[rd_ptr];
    assign pop     = valid_o & ready_i;
    assign full    = (count_o == OccFull);
    assign wr_ok   = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Circular FIFO; a push into a full FIFO only succeeds alongside a pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_o   <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !pop) begin
                count_o <= count_o + 1'b1;
            end else if (!wr_ok && pop) begin
                count_o <= count_o - 1'b1;
            end
            if (clear_i) begin
                overrun_o <= 1'b0;
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule
